// File: rtl/stopwatch_pkg.sv
// Shared types for the stopwatch control slice.
// State encoding, scan digit indices, default limits, BCD helpers.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_PAUSED = 2'd0,
    ST_RUN    = 2'd1,
    ST_ADJUST = 2'd2
  } state_e;

  localparam logic [1:0] DIG_SEC_ONES = 2'd0;
  localparam logic [1:0] DIG_SEC_TENS = 2'd1;
  localparam logic [1:0] DIG_MIN_ONES = 2'd2;
  localparam logic [1:0] DIG_MIN_TENS = 2'd3;

  localparam int unsigned DEF_MAX_MIN = 59;
  localparam int unsigned DEF_MAX_SEC = 59;

  function automatic logic [3:0] bcd_tens(
    input logic [5:0] v
  );
    return 4'(v / 6'd10);
  endfunction

  function automatic logic [3:0] bcd_ones(
    input logic [5:0] v
  );
    return 4'(v % 6'd10);
  endfunction

  function automatic logic [5:0] wrap_inc(
    input logic [5:0] v,
    input logic [5:0] max
  );
    return (v >= max) ? 6'd0 : v + 6'd1;
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_digit_scan.sv
// digit_scan: 4-digit scan index, anode drive, digit mux, field blanking.
// In: clk, rst(async low), tick_fast, min/sec, adjusting, blink, sel. Out: an, digit, blank.
module digit_scan
  import stopwatch_pkg::*;
#(
  parameter bit AN_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_fast,
  input  logic [5:0] min_val,
  input  logic [5:0] sec_val,
  input  logic       adjusting,
  input  logic       blink,
  input  logic       sel,
  output logic [3:0] an,
  output logic [3:0] digit,
  output logic       blank
);

  localparam logic [3:0] AN_RST =
    AN_ACTIVE_LOW ? 4'b1110 : 4'b0001;

  logic [1:0] idx_q, idx_d;
  logic [3:0] an_q, an_d;
  logic [3:0] digit_q, digit_d;
  logic       blank_q, blank_d;
  logic [3:0] onehot;

  // Outputs follow the next index so they move one cycle after tick_fast.
  always_comb begin
    idx_d   = tick_fast ? idx_q + 2'd1 : idx_q;
    onehot  = 4'b0001 << idx_d;
    an_d    = AN_ACTIVE_LOW ? ~onehot : onehot;
    digit_d = '0;
    unique case (1'b1)
      onehot[DIG_SEC_ONES]: digit_d = bcd_ones(sec_val);
      onehot[DIG_SEC_TENS]: digit_d = bcd_tens(sec_val);
      onehot[DIG_MIN_ONES]: digit_d = bcd_ones(min_val);
      onehot[DIG_MIN_TENS]: digit_d = bcd_tens(min_val);
      default:              digit_d = '0;
    endcase
    // idx bit 1 set means a minutes digit.
    blank_d = adjusting & blink & (idx_d[1] == sel);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q   <= DIG_SEC_ONES;
      an_q    <= AN_RST;
      digit_q <= '0;
      blank_q <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      an_q    <= an_d;
      digit_q <= digit_d;
      blank_q <= blank_d;
    end
  end

  assign an    = an_q;
  assign digit = digit_q;
  assign blank = blank_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: run/pause/adjust FSM, MM:SS counters, display scan.
// Optional lap hold via STOPWATCH_LAP_EN (adds lap_pulse input).
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned MAX_MIN       = DEF_MAX_MIN,
  parameter int unsigned MAX_SEC       = DEF_MAX_SEC,
  parameter bit          AN_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       tick_2hz,
  input  logic       tick_fast,
  input  logic       tick_blink,
  input  logic       pause_pulse,
  input  logic       clear_pulse,
  input  logic       adj,
  input  logic       sel,
`ifdef STOPWATCH_LAP_EN
  input  logic       lap_pulse,
`endif
  output logic [3:0] an,
  output logic [3:0] digit,
  output logic       blank,
  output logic       running
);

  localparam logic [5:0] MAX_M = 6'(MAX_MIN);
  localparam logic [5:0] MAX_S = 6'(MAX_SEC);

  state_e     state_q, state_d;
  logic [5:0] min_q, min_d;
  logic [5:0] sec_q, sec_d;
  logic       blink_q, blink_d;
  logic [5:0] disp_min, disp_sec;

  always_comb begin
    state_d = state_q;
    if (adj)
      state_d = ST_ADJUST;
    else if (state_q == ST_ADJUST)
      state_d = ST_PAUSED;
    else if (pause_pulse && state_q == ST_RUN)
      state_d = ST_PAUSED;
    else if (pause_pulse && state_q == ST_PAUSED)
      state_d = ST_RUN;
  end

  always_comb begin
    min_d = min_q;
    sec_d = sec_q;
    if (clear_pulse) begin
      min_d = '0;
      sec_d = '0;
    end else if (state_q == ST_RUN && tick_1hz) begin
      if (sec_q >= MAX_S) begin
        sec_d = '0;
        min_d = wrap_inc(min_q, MAX_M);
      end else begin
        sec_d = sec_q + 6'd1;
      end
    end else if (state_q == ST_ADJUST && tick_2hz) begin
      // Fields adjust independently, no carry.
      if (sel)
        min_d = wrap_inc(min_q, MAX_M);
      else
        sec_d = wrap_inc(sec_q, MAX_S);
    end
  end

  // Entering adjust starts the blink in the visible phase.
  always_comb begin
    blink_d = blink_q;
    if (state_d == ST_ADJUST && state_q != ST_ADJUST)
      blink_d = 1'b0;
    else if (tick_blink)
      blink_d = ~blink_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_PAUSED;
      min_q   <= '0;
      sec_q   <= '0;
      blink_q <= 1'b0;
    end else begin
      state_q <= state_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      blink_q <= blink_d;
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic       lap_on_q, lap_on_d;
  logic [5:0] lap_min_q, lap_min_d;
  logic [5:0] lap_sec_q, lap_sec_d;

  // Lap holds the pre-tick count; any exit from RUN drops it.
  always_comb begin
    lap_on_d  = lap_on_q;
    lap_min_d = lap_min_q;
    lap_sec_d = lap_sec_q;
    if (clear_pulse || state_q != ST_RUN
        || state_d != ST_RUN) begin
      lap_on_d = 1'b0;
    end else if (lap_pulse) begin
      lap_on_d = ~lap_on_q;
      if (!lap_on_q) begin
        lap_min_d = min_q;
        lap_sec_d = sec_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lap_on_q  <= 1'b0;
      lap_min_q <= '0;
      lap_sec_q <= '0;
    end else begin
      lap_on_q  <= lap_on_d;
      lap_min_q <= lap_min_d;
      lap_sec_q <= lap_sec_d;
    end
  end

  assign disp_min = lap_on_q ? lap_min_q : min_q;
  assign disp_sec = lap_on_q ? lap_sec_q : sec_q;
`else
  assign disp_min = min_q;
  assign disp_sec = sec_q;
`endif

  digit_scan #(
    .AN_ACTIVE_LOW (AN_ACTIVE_LOW)
  ) u_scan (
    .clk       (clk),
    .rst       (rst),
    .tick_fast (tick_fast),
    .min_val   (disp_min),
    .sec_val   (disp_sec),
    .adjusting (state_q == ST_ADJUST),
    .blink     (blink_q),
    .sel       (sel),
    .an        (an),
    .digit     (digit),
    .blank     (blank)
  );

  assign running = (state_q == ST_RUN);

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl.
// Each scan step queues its expected an/digit/blank/running.
module tb_stopwatch_ctrl;

  localparam int P_1HZ   = 0;
  localparam int P_2HZ   = 1;
  localparam int P_FAST  = 2;
  localparam int P_BLINK = 3;
  localparam int P_PAUSE = 4;
  localparam int P_CLEAR = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic tick_1hz = 1'b0;
  logic tick_2hz = 1'b0;
  logic tick_fast = 1'b0;
  logic tick_blink = 1'b0;
  logic pause_pulse = 1'b0;
  logic clear_pulse = 1'b0;
  logic adj = 1'b0;
  logic sel = 1'b0;
  logic [3:0] an;
  logic [3:0] digit;
  logic blank;
  logic running;

  typedef struct packed {
    logic [3:0] an;
    logic [3:0] digit;
    logic       blank;
    logic       running;
  } obs_t;

  obs_t  exp_q[$];
  int    passed = 0;
  int    total = 0;
  int    scan_idx = 0;
  string cur_tag = "none";
  logic  fast_d = 1'b0;

  always #5 clk = ~clk;

  stopwatch_ctrl #(
    .MAX_MIN       (59),
    .MAX_SEC       (59),
    .AN_ACTIVE_LOW (1'b1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tick_1hz    (tick_1hz),
    .tick_2hz    (tick_2hz),
    .tick_fast   (tick_fast),
    .tick_blink  (tick_blink),
    .pause_pulse (pause_pulse),
    .clear_pulse (clear_pulse),
    .adj         (adj),
    .sel         (sel),
`ifdef STOPWATCH_LAP_EN
    .lap_pulse   (1'b0),
`endif
    .an          (an),
    .digit       (digit),
    .blank       (blank),
    .running     (running)
  );

  always @(posedge clk) fast_d <= tick_fast;

  // Monitor: a scan step is presented the cycle after tick_fast.
  always @(negedge clk) begin : mon
    obs_t got;
    obs_t e;
    if (fast_d) begin
      got = {an, digit, blank, running};
      total++;
      if (exp_q.size() == 0) begin
        $display("FAIL %s unexpected scan an=%b digit=%0d",
                 cur_tag, an, digit);
      end else begin
        e = exp_q.pop_front();
        if (got === e) passed++;
        else
          $display({"FAIL %s got an=%b dig=%0d blank=%b run=%b",
                    " exp an=%b dig=%0d blank=%b run=%b"},
                   cur_tag, got.an, got.digit, got.blank,
                   got.running, e.an, e.digit, e.blank,
                   e.running);
      end
    end
  end

  task automatic check(input string n,
                       input logic [3:0] got,
                       input logic [3:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s got=%b exp=%b", n, got, exp);
  endtask

  task automatic pulse(input int which, input int n);
    repeat (n) begin
      @(negedge clk);
      case (which)
        P_1HZ:   tick_1hz = 1'b1;
        P_2HZ:   tick_2hz = 1'b1;
        P_FAST:  tick_fast = 1'b1;
        P_BLINK: tick_blink = 1'b1;
        P_PAUSE: pause_pulse = 1'b1;
        default: clear_pulse = 1'b1;
      endcase
      @(negedge clk);
      tick_1hz = 1'b0;
      tick_2hz = 1'b0;
      tick_fast = 1'b0;
      tick_blink = 1'b0;
      pause_pulse = 1'b0;
      clear_pulse = 1'b0;
    end
  endtask

  // Scan all four digits, expecting MM:SS, running and blank mask.
  task automatic show(input string tag, input int mm,
                      input int ss, input bit run,
                      input logic [3:0] bmask);
    int w;
    cur_tag = tag;
    for (int k = 0; k < 4; k++) begin
      obs_t e;
      int v;
      scan_idx = (scan_idx + 1) % 4;
      case (scan_idx)
        0: v = ss % 10;
        1: v = ss / 10;
        2: v = mm % 10;
        default: v = mm / 10;
      endcase
      e.an = ~(4'b0001 << scan_idx);
      e.digit = 4'(v);
      e.blank = bmask[scan_idx];
      e.running = run;
      exp_q.push_back(e);
      pulse(P_FAST, 1);
    end
    w = 0;
    while (exp_q.size() != 0 && w < 10) begin
      @(negedge clk);
      w++;
    end
    if (exp_q.size() != 0) begin
      total++;
      $display("FAIL %s timeout pending=%0d exp=0",
               tag, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_an", an, 4'b1110);
    check("rst_digit", digit, 4'd0);
    check("rst_blank", {3'b0, blank}, 4'd0);
    check("rst_running", {3'b0, running}, 4'd0);
    rst = 1'b1;
    @(negedge clk);

    pulse(P_PAUSE, 1);
    pulse(P_1HZ, 5);
    show("run_00_05", 0, 5, 1, 4'b0000);

    pulse(P_1HZ, 54);
    show("run_00_59", 0, 59, 1, 4'b0000);
    pulse(P_1HZ, 1);
    show("carry_01_00", 1, 0, 1, 4'b0000);

    adj = 1'b1;
    sel = 1'b1;
    pulse(P_2HZ, 58);
    sel = 1'b0;
    pulse(P_2HZ, 59);
    show("adj_59_59", 59, 59, 0, 4'b0000);
    adj = 1'b0;
    pulse(P_PAUSE, 1);
    pulse(P_1HZ, 1);
    show("wrap_00_00", 0, 0, 1, 4'b0000);

    pulse(P_1HZ, 10);
    show("run_00_10", 0, 10, 1, 4'b0000);
    pulse(P_PAUSE, 1);
    pulse(P_1HZ, 3);
    show("paused_hold", 0, 10, 0, 4'b0000);
    pulse(P_PAUSE, 1);
    show("resume", 0, 10, 1, 4'b0000);

    pulse(P_1HZ, 48);
    show("run_00_58", 0, 58, 1, 4'b0000);
    adj = 1'b1;
    sel = 1'b0;
    pulse(P_2HZ, 3);
    show("adj_sec_wrap", 0, 1, 0, 4'b0000);
    sel = 1'b1;
    pulse(P_2HZ, 2);
    show("adj_min", 2, 1, 0, 4'b0000);

    pulse(P_2HZ, 1);
    sel = 1'b0;
    pulse(P_2HZ, 6);
    adj = 1'b0;
    pulse(P_PAUSE, 1);
    show("run_03_07", 3, 7, 1, 4'b0000);
    @(negedge clk);
    clear_pulse = 1'b1;
    tick_1hz = 1'b1;
    @(negedge clk);
    clear_pulse = 1'b0;
    tick_1hz = 1'b0;
    show("clear_wins", 0, 0, 1, 4'b0000);

    adj = 1'b1;
    sel = 1'b1;
    pulse(P_BLINK, 1);
    show("blank_min", 0, 0, 0, 4'b1100);
    sel = 1'b0;
    show("blank_sec", 0, 0, 0, 4'b0011);
    pulse(P_BLINK, 1);
    show("blink_off", 0, 0, 0, 4'b0000);

    adj = 1'b0;
    pulse(P_BLINK, 1);
    show("paused_no_blank", 0, 0, 0, 4'b0000);
    adj = 1'b1;
    sel = 1'b1;
    show("entry_resets_blink", 0, 0, 0, 4'b0000);

    adj = 1'b0;
    pulse(P_PAUSE, 1);
    pulse(P_1HZ, 2);
    show("run_00_02", 0, 2, 1, 4'b0000);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("async_rst_running", {3'b0, running}, 4'd0);
    check("async_rst_an", an, 4'b1110);
    check("async_rst_digit", digit, 4'd0);
    @(negedge clk);
    rst = 1'b1;
    scan_idx = 0;
    pulse(P_PAUSE, 1);
    show("post_rst", 0, 0, 1, 4'b0000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
